// File: rtl/ext_bus_serial_tx_if.sv
// External MC6803-style bus seen by the serial transmitter.
// master: CPU side driving address/data/strobe; slave: the responder block.
interface ext_bus_serial_tx_if;
  logic [15:0] ADDRESS;
  logic [7:0]  DATA_OUT;
  logic        rw;
  logic        E_CLK;
  logic [7:0]  DATA_IN;
  logic        SEL;

  modport master (
    output ADDRESS, DATA_OUT, rw, E_CLK,
    input  DATA_IN, SEL
  );

  modport slave (
    input  ADDRESS, DATA_OUT, rw, E_CLK,
    output DATA_IN, SEL
  );
endinterface

// File: rtl/ext_bus_serial_tx.sv
// Memory-mapped async serial transmitter on the external bus.
// CPU pushes bytes into a TX FIFO; an FSM shifts them out on TXD as 8N1.
// Optional feature macro: EXT_TX_PARITY_EN inserts a parity bit (11-bit frame).
module ext_bus_serial_tx #(
  parameter logic [15:0] BASE_ADDR  = 16'h4000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd103
) (
  input  logic                      Clk,
  input  logic                      RST_N,
  ext_bus_serial_tx_if.slave        bus,
  output logic                      TXD,
  output logic                      TX_IRQ
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

`ifdef EXT_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  // Bus decode
  logic       sel, wr, rd;
  logic [1:0] offset;
  logic       wr_ctrl, push, wr_div_hi, wr_div_lo, rd_status, flush;

  assign sel       = bus.E_CLK & (bus.ADDRESS[15:2] == BASE_ADDR[15:2]);
  assign wr        = sel & ~bus.rw;
  assign rd        = sel & bus.rw;
  assign offset    = bus.ADDRESS[1:0];
  assign wr_ctrl   = wr & (offset == 2'd0);
  assign push      = wr & (offset == 2'd1);
  assign wr_div_hi = wr & (offset == 2'd2);
  assign wr_div_lo = wr & (offset == 2'd3);
  assign rd_status = rd & (offset == 2'd0);
  assign flush     = wr_ctrl & bus.DATA_OUT[1];
  assign bus.SEL   = sel;

  // Control / divisor state
  logic        te_q, tie_q, tie_d, par_odd_q, ovr_q, ovr_d;
  logic [15:0] div_q;

  // FIFO state
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            full, push_ok, overrun, can_pop, pop;

  // Transmit FSM / datapath state
  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_bit_q, par_bit_d;
  logic        txd_q, txd_d, irq_q, irq_d;
  logic        baud_done;
  logic [7:0]  head;

  assign full      = (count_q == CntFull);
  assign push_ok   = push & ~full;
  assign overrun   = push & full;
  // A flush in the same cycle wins: nothing is popped from a FIFO being emptied.
  assign can_pop   = te_q & (count_q != '0) & ~flush;
  assign baud_done = (baud_q == 16'd0);
  assign head      = mem[rd_ptr_q];
  assign tie_d     = wr_ctrl ? bus.DATA_OUT[3] : tie_q;

  // Control and divisor registers written from the bus
  always_ff @(posedge Clk or negedge RST_N) begin
    if (!RST_N) begin
      te_q  <= 1'b0;
      tie_q <= 1'b0;
      div_q <= DIV_RESET;
    end else begin
      if (wr_ctrl) begin
        te_q  <= bus.DATA_OUT[0];
        tie_q <= bus.DATA_OUT[3];
      end
      if (wr_div_hi) div_q[15:8] <= bus.DATA_OUT;
      if (wr_div_lo) div_q[7:0]  <= bus.DATA_OUT;
    end
  end

`ifdef EXT_TX_PARITY_EN
  // Parity-sense bit, only present when the parity feature is built
  always_ff @(posedge Clk or negedge RST_N) begin
    if (!RST_N)       par_odd_q <= 1'b0;
    else if (wr_ctrl) par_odd_q <= bus.DATA_OUT[2];
  end
`else
  assign par_odd_q = 1'b0;
`endif

  // Sticky overrun: a same-cycle overrun beats the STATUS-read clear
  always_comb begin
    ovr_d = ovr_q;
    if (rd_status) ovr_d = 1'b0;
    if (overrun)   ovr_d = 1'b1;
  end

  // FIFO occupancy: flush empties outright, otherwise push/pop net out
  always_comb begin
    count_d = count_q + CntW'(push_ok) - CntW'(pop);
    if (flush) count_d = '0;
  end

  // FIFO storage (no reset needed, contents qualified by count)
  always_ff @(posedge Clk) begin
    if (push_ok) mem[wr_ptr_q] <= bus.DATA_OUT;
  end

  // FIFO pointers, count and overrun flag
  always_ff @(posedge Clk or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      ovr_q   <= ovr_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (flush)    rd_ptr_q <= wr_ptr_q;
      else if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // FSM state register
  always_ff @(posedge Clk or negedge RST_N) begin
    if (!RST_N) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next-state: each non-idle state ends when the baud counter hits zero
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (can_pop) state_d = StStart;
      StStart: if (baud_done) state_d = StData;
      StData: begin
        if (baud_done && (bit_q == 3'd7)) begin
`ifdef EXT_TX_PARITY_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end
      end
`ifdef EXT_TX_PARITY_EN
      StParity: if (baud_done) state_d = StStop;
`endif
      // Back-to-back frames skip idle entirely
      StStop:  if (baud_done) state_d = can_pop ? StStart : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs and datapath next values; TXD/IRQ are computed from next state
  always_comb begin
    pop       = can_pop & ((state_q == StIdle) | ((state_q == StStop) & baud_done));
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    if (pop) begin
      baud_d    = div_q;
      shift_d   = head;
      par_bit_d = (^head) ^ par_odd_q;
    end else if (state_q != StIdle) begin
      baud_d = baud_done ? div_q : (baud_q - 16'd1);
      if (baud_done && (state_q == StStart)) bit_d = 3'd0;
      if (baud_done && (state_q == StData)) begin
        bit_d   = bit_q + 3'd1;
        shift_d = {1'b0, shift_q[7:1]};
      end
    end

    txd_d = 1'b1;
    unique case (state_d)
      StStart:  txd_d = 1'b0;
      StData:   txd_d = shift_d[0];
`ifdef EXT_TX_PARITY_EN
      StParity: txd_d = par_bit_d;
`endif
      default:  txd_d = 1'b1;
    endcase

    irq_d = tie_d & (count_d == '0) & (state_d == StIdle);
  end

  // Datapath and registered serial/interrupt outputs
  always_ff @(posedge Clk or negedge RST_N) begin
    if (!RST_N) begin
      baud_q    <= 16'd0;
      bit_q     <= 3'd0;
      shift_q   <= 8'd0;
      par_bit_q <= 1'b0;
      txd_q     <= 1'b1;
      irq_q     <= 1'b0;
    end else begin
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      txd_q     <= txd_d;
      irq_q     <= irq_d;
    end
  end

  assign TXD    = txd_q;
  assign TX_IRQ = irq_q;

  // Read mux: combinational, zero unless this is a selected read
  logic [7:0] status, ctrl_rd, rdata;
  logic [3:0] cnt4;

  assign cnt4    = 4'(count_q);
  assign status  = {~full, (count_q == '0) & (state_q == StIdle), ovr_q, 1'b0, cnt4};
  assign ctrl_rd = {4'b0000, tie_q, par_odd_q, 1'b0, te_q};

  always_comb begin
    rdata = 8'h00;
    if (rd) begin
      case (offset)
        2'd0:    rdata = status;
        2'd1:    rdata = ctrl_rd;
        2'd2:    rdata = div_q[15:8];
        default: rdata = div_q[7:0];
      endcase
    end
  end

  assign bus.DATA_IN = rdata;

endmodule
